router_sync_param: RTL and testbench
====================================

# router_sync_param

Parametrised address-decode, write-steering and output-watchdog block for an N-port packet router; successor to the fixed 1x3 synchroniser. It sits between the router FSM/register stage and the N output FIFOs. It latches the destination address at header detect and steers write enables to one FIFO. It reports that FIFO's full status back to the FSM, drives per-port valid-out from FIFO empties, and soft-resets any FIFO whose contents go unread for TIMEOUT cycles. New over the 1x3 version: arbitrary port count, configurable timeout, and an invalid-address error path that drops the packet instead of writing a wrong FIFO.

## Interface
- NUM_PORTS, 3: number of output FIFOs (2..16)
- ADDR_W, 2: address field width; ≥ $clog2(NUM_PORTS), min 1
- TIMEOUT, 30: consecutive unread-valid cycles before soft reset (≥ 2)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- detect_add  in  1  header-detect strobe from FSM; latches din
- write_enb_reg  in  1  FSM write request for current byte
- din  in  ADDR_W  destination address (low bits of header)
- full  in  NUM_PORTS  per-FIFO full flags
- empty  in  NUM_PORTS  per-FIFO empty flags
- read_enb  in  NUM_PORTS  per-FIFO read enables from output side
- wr_enb  out  NUM_PORTS  one-hot (or zero) FIFO write enable
- fifo_full  out  1  full flag of addressed FIFO
- vld_out  out  NUM_PORTS  per-port data-valid to output side
- soft_rst  out  NUM_PORTS  per-FIFO soft-reset pulse
- addr_err  out  1  latched address ≥ NUM_PORTS

## Operation
- Address register addr_q (ADDR_W) and addr_vld_q. At posedge with detect_add=1: addr_q←din; addr_vld_q←(din<NUM_PORTS). Otherwise hold.
- addr_err = addr_q is set and !addr_vld_q. Registered: set by the detect of an invalid address, cleared by the next valid detect.
- wr_enb (combinational) = write_enb_reg && addr_vld_q ? (1<<addr_q) : 0. Invalid or no address gives zero writes, so the packet is dropped.
- fifo_full (combinational) = addr_vld_q ? full[addr_q] : 0. Invalid address never stalls the FSM.
- vld_out[i] = !empty[i] (combinational).
- Per-port watchdog cnt[i], width $clog2(TIMEOUT). Evaluated at each posedge:
  - if !vld_out[i] or read_enb[i]: cnt←0, soft_rst[i]←0
  - else if cnt==TIMEOUT-1: cnt←0, soft_rst[i]←1
  - else: cnt←cnt+1, soft_rst[i]←0
- Ports are independent. Any subset may pulse soft_rst in the same cycle.

## Timing
- Reset (rst=0, async): addr_q=0, addr_vld_q=0, addr_err=0, all cnt=0, soft_rst=0. Therefore wr_enb=0 and fifo_full=0 until the first detect. vld_out follows empty even in reset.
- Address latency 1 cycle. detect_add and write_enb_reg in the same cycle steer with the old addr_q. The new address takes effect from the next cycle.
- wr_enb, fifo_full and vld_out have zero latency from their inputs.
- soft_rst[i] rises at the edge ending the TIMEOUT-th consecutive cycle of vld_out[i]=1, read_enb[i]=0, and stays high exactly 1 cycle.
- If still unread after a pulse, the next pulse comes TIMEOUT cycles later.
- A read_enb[i] in the final qualifying cycle suppresses the pulse and clears cnt.
- rst asserted mid-count clears cnt and soft_rst immediately. The count restarts from 0 after release.
- Empty rising mid-count clears cnt at the next edge.

## Structure
- Shared package router_pkg: default NUM_PORTS, ADDR_W, TIMEOUT constants, and a port-index typedef sized by ADDR_W.
- One sub-module, router_sync_wdt (single-port counter plus soft_rst flop, TIMEOUT parameter), instantiated NUM_PORTS times via generate.
- Top holds the address register, error flag, and combinational steering and full mux.

## Test plan
- Reset, then detect_add with din=2 and write_enb_reg=1 → next cycle wr_enb=3'b100; full=3'b100 gives fifo_full=1, full=3'b011 gives fifo_full=0.
- Detect din=3 (NUM_PORTS=3), write_enb_reg=1, full=3'b111 → addr_err=1, wr_enb=0, fifo_full=0. Then detect din=1 → addr_err=0, wr_enb=3'b010.
- empty[2]=0, read_enb[2]=0 held → soft_rst[2] pulses for 1 cycle exactly 30 cycles after empty falls, and again 30 cycles later. soft_rst[0..1] stay 0.
- Same as previous, but read_enb[2]=1 on cycle 29 → no pulse; the counter restarts, and a pulse follows 30 cycles after read drops.
- empty=3'b000, no reads, and rst pulsed low at cycle 15 → soft_rst stays 0 and the first pulse comes 30 cycles after rst release.
- NUM_PORTS=5, ADDR_W=3, TIMEOUT=4: sweep din 0..7 → one-hot wr_enb for 0..4 and addr_err for 5..7. An unread port gives soft_rst every 4 cycles.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared defaults, port-index type and counter sizing for the router sync block
package router_pkg;
  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_ADDR_W    = 2;
  localparam int DEF_TIMEOUT   = 30;
  typedef logic [DEF_ADDR_W-1:0] port_idx_t;
  function automatic int cnt_w(input int t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction
endpackage

// File: rtl/router_sync_param_if.sv
// router_sync_param_if: FSM/FIFO-side bus of the router sync block
// master drives detect_add, write_enb_reg, din, full, empty, read_enb;
// slave (the router sync block) drives wr_enb, fifo_full, vld_out, soft_rst, addr_err
interface router_sync_param_if
  import router_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W
);
  logic                 detect_add;
  logic                 write_enb_reg;
  logic [ADDR_W-1:0]    din;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] read_enb;
  logic [NUM_PORTS-1:0] wr_enb;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] soft_rst;
  logic                 addr_err;
  modport master (
    output detect_add, write_enb_reg, din, full, empty, read_enb,
    input  wr_enb, fifo_full, vld_out, soft_rst, addr_err
  );
  modport slave (
    input  detect_add, write_enb_reg, din, full, empty, read_enb,
    output wr_enb, fifo_full, vld_out, soft_rst, addr_err
  );
endinterface

// File: rtl/router_sync_wdt.sv
// router_sync_wdt: single-port unread-data watchdog issuing a one-cycle soft reset
// clk/rst (async, active-low); i_vld port has data; i_rd port is read; o_soft_rst pulse
module router_sync_wdt
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  input  logic i_rd,
  output logic o_soft_rst
);
  localparam int W = cnt_w(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] r_cnt;
  logic         r_soft_rst;
  logic         w_hit;
  assign w_hit      = i_vld && !i_rd && r_cnt == LAST;
  assign o_soft_rst = r_soft_rst;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt      <= '0;
      r_soft_rst <= 1'b0;
    end else begin
      r_cnt      <= (!i_vld || i_rd || w_hit) ? '0 : r_cnt + 1'b1;
      r_soft_rst <= w_hit;
    end
endmodule

// File: rtl/router_sync_param.sv
// router_sync_param: address latch, write steering, full mux and per-port watchdogs for an N-port router
// clk/rst (async, active-low); bus carries FSM strobes, FIFO flags and the steered/status outputs
module router_sync_param
  import router_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  router_sync_param_if.slave bus
);
  localparam logic [NUM_PORTS-1:0] ONE = 1;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_addr_vld;
  logic                 r_addr_err;
  logic [NUM_PORTS-1:0] w_sel;
  logic [NUM_PORTS-1:0] w_vld;
  logic [NUM_PORTS-1:0] w_soft_rst;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_addr     <= '0;
      r_addr_vld <= 1'b0;
      r_addr_err <= 1'b0;
    end else if (bus.detect_add) begin
      r_addr     <= bus.din;
      r_addr_vld <= 32'(bus.din) < NUM_PORTS;
      r_addr_err <= 32'(bus.din) >= NUM_PORTS;
    end
  // w_sel is zero for an invalid address, so writes are dropped and full never stalls the FSM
  assign w_sel         = r_addr_vld ? ONE << r_addr : '0;
  assign w_vld         = ~bus.empty;
  assign bus.wr_enb    = bus.write_enb_reg ? w_sel : '0;
  assign bus.fifo_full = |(bus.full & w_sel);
  assign bus.vld_out   = w_vld;
  assign bus.addr_err  = r_addr_err;
  assign bus.soft_rst  = w_soft_rst;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wdt
    router_sync_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
      .clk       (clk),
      .rst       (rst),
      .i_vld     (w_vld[i]),
      .i_rd      (bus.read_enb[i]),
      .o_soft_rst(w_soft_rst[i])
    );
  end
endmodule

// File: tb/tb_router_sync_param.sv
// tb_router_sync_param: randomized and directed checks of router_sync_param against a behavioural model
module tb_router_sync_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  router_sync_param_if bus3 ();
  router_sync_param_if #(.NUM_PORTS(5), .ADDR_W(3)) bus5 ();

  router_sync_param dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  router_sync_param #(.NUM_PORTS(5), .ADDR_W(3), .TIMEOUT(4)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  // model: latched address and length of the current unbroken unread-valid run per port
  int ea3, ea5;
  bit av3, av5, ae3, ae5;
  int run3 [3];
  int run5 [5];
  always @(posedge clk or negedge rst)
    if (!rst) begin
      ea3 <= 0; av3 <= 0; ae3 <= 0;
      ea5 <= 0; av5 <= 0; ae5 <= 0;
      for (int i = 0; i < 3; i++) run3[i] <= 0;
      for (int i = 0; i < 5; i++) run5[i] <= 0;
    end else begin
      if (bus3.detect_add) begin
        ea3 <= int'(bus3.din); av3 <= bus3.din < 2'd3; ae3 <= bus3.din >= 2'd3;
      end
      if (bus5.detect_add) begin
        ea5 <= int'(bus5.din); av5 <= bus5.din < 3'd5; ae5 <= bus5.din >= 3'd5;
      end
      for (int i = 0; i < 3; i++) run3[i] <= (!bus3.empty[i] && !bus3.read_enb[i]) ? run3[i] + 1 : 0;
      for (int i = 0; i < 5; i++) run5[i] <= (!bus5.empty[i] && !bus5.read_enb[i]) ? run5[i] + 1 : 0;
    end

  function automatic logic [2:0] exp_wr3();
    return (bus3.write_enb_reg && av3) ? 3'(1 << ea3) : 3'b0;
  endfunction
  function automatic logic [4:0] exp_wr5();
    return (bus5.write_enb_reg && av5) ? 5'(1 << ea5) : 5'b0;
  endfunction
  function automatic logic exp_ff3();
    return av3 ? bus3.full[ea3] : 1'b0;
  endfunction
  function automatic logic exp_ff5();
    return av5 ? bus5.full[ea5] : 1'b0;
  endfunction
  // a pulse is due whenever the unread run has just completed a whole multiple of TIMEOUT cycles
  function automatic logic [2:0] exp_sr3();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = run3[i] > 0 && run3[i] % 30 == 0;
    return r;
  endfunction
  function automatic logic [4:0] exp_sr5();
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = run5[i] > 0 && run5[i] % 4 == 0;
    return r;
  endfunction

  task automatic test_reset();
    bus3.detect_add = 0; bus3.write_enb_reg = 1; bus3.din = 2'd2; bus3.full = 3'b111;
    bus3.empty = 3'b010; bus3.read_enb = 0;
    bus5.detect_add = 0; bus5.write_enb_reg = 1; bus5.din = 3'd1; bus5.full = 5'h1f;
    bus5.empty = 5'h1f; bus5.read_enb = 0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus3.wr_enb !== 3'b000) begin bad++; $display("FAIL reset_wr_enb got=%b exp=000", bus3.wr_enb); end
    total++; if (bus3.fifo_full !== 1'b0) begin bad++; $display("FAIL reset_fifo_full got=%b exp=0", bus3.fifo_full); end
    total++; if (bus3.addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b exp=0", bus3.addr_err); end
    total++; if (bus3.soft_rst !== 3'b000) begin bad++; $display("FAIL reset_soft_rst got=%b exp=000", bus3.soft_rst); end
    total++; if (bus3.vld_out !== 3'b101) begin bad++; $display("FAIL reset_vld_out got=%b exp=101", bus3.vld_out); end
    total++; if (bus5.wr_enb !== 5'b0) begin bad++; $display("FAIL reset_wr_enb5 got=%b exp=00000", bus5.wr_enb); end
    bus3.empty = 3'b111;
    rst = 1;
    @(negedge clk);
    #1;
    total++; if (bus3.wr_enb !== 3'b000) begin bad++; $display("FAIL no_detect_wr_enb got=%b exp=000", bus3.wr_enb); end
  endtask

  task automatic test_decode();
    @(negedge clk); bus3.detect_add = 1; bus3.din = 2'd2; bus3.write_enb_reg = 1; bus3.full = 3'b000;
    #1;
    total++; if (bus3.wr_enb !== 3'b000) begin bad++; $display("FAIL same_cycle_old_addr got=%b exp=000", bus3.wr_enb); end
    @(negedge clk); bus3.detect_add = 0;
    #1;
    total++; if (bus3.wr_enb !== 3'b100) begin bad++; $display("FAIL steer_port2 got=%b exp=100", bus3.wr_enb); end
    bus3.full = 3'b100; #1;
    total++; if (bus3.fifo_full !== 1'b1) begin bad++; $display("FAIL full_port2 got=%b exp=1", bus3.fifo_full); end
    bus3.full = 3'b011; #1;
    total++; if (bus3.fifo_full !== 1'b0) begin bad++; $display("FAIL notfull_port2 got=%b exp=0", bus3.fifo_full); end
    @(negedge clk); bus3.detect_add = 1; bus3.din = 2'd3; bus3.full = 3'b111;
    #1;
    total++; if (bus3.wr_enb !== 3'b100) begin bad++; $display("FAIL detect_keeps_old got=%b exp=100", bus3.wr_enb); end
    @(negedge clk); bus3.detect_add = 0;
    #1;
    total++; if (bus3.addr_err !== 1'b1) begin bad++; $display("FAIL invalid_addr_err got=%b exp=1", bus3.addr_err); end
    total++; if (bus3.wr_enb !== 3'b000) begin bad++; $display("FAIL invalid_wr_enb got=%b exp=000", bus3.wr_enb); end
    total++; if (bus3.fifo_full !== 1'b0) begin bad++; $display("FAIL invalid_fifo_full got=%b exp=0", bus3.fifo_full); end
    @(negedge clk); bus3.detect_add = 1; bus3.din = 2'd1;
    @(negedge clk); bus3.detect_add = 0;
    #1;
    total++; if (bus3.addr_err !== 1'b0) begin bad++; $display("FAIL valid_clears_err got=%b exp=0", bus3.addr_err); end
    total++; if (bus3.wr_enb !== 3'b010) begin bad++; $display("FAIL steer_port1 got=%b exp=010", bus3.wr_enb); end
  endtask

  task automatic test_random_decode();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      bus3.detect_add = $urandom % 3 == 0; bus3.din = 2'($urandom); bus3.write_enb_reg = 1'($urandom); bus3.full = 3'($urandom);
      bus5.detect_add = $urandom % 3 == 0; bus5.din = 3'($urandom); bus5.write_enb_reg = 1'($urandom); bus5.full = 5'($urandom);
      #1;
      total++; if (bus3.wr_enb !== exp_wr3()) begin bad++; $display("FAIL rnd_wr_enb3 c=%0d got=%b exp=%b", c, bus3.wr_enb, exp_wr3()); end
      total++; if (bus3.fifo_full !== exp_ff3()) begin bad++; $display("FAIL rnd_fifo_full3 c=%0d got=%b exp=%b", c, bus3.fifo_full, exp_ff3()); end
      total++; if (bus3.addr_err !== ae3) begin bad++; $display("FAIL rnd_addr_err3 c=%0d got=%b exp=%b", c, bus3.addr_err, ae3); end
      total++; if (bus5.wr_enb !== exp_wr5()) begin bad++; $display("FAIL rnd_wr_enb5 c=%0d got=%b exp=%b", c, bus5.wr_enb, exp_wr5()); end
      total++; if (bus5.fifo_full !== exp_ff5()) begin bad++; $display("FAIL rnd_fifo_full5 c=%0d got=%b exp=%b", c, bus5.fifo_full, exp_ff5()); end
      total++; if (bus5.addr_err !== ae5) begin bad++; $display("FAIL rnd_addr_err5 c=%0d got=%b exp=%b", c, bus5.addr_err, ae5); end
    end
    bus3.detect_add = 0; bus5.detect_add = 0;
  endtask

  task automatic test_watchdog();
    int first = -1, second = -1, n = 0;
    @(negedge clk); bus3.empty = 3'b111; bus3.read_enb = 0;
    @(negedge clk); bus3.empty = 3'b011;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk); #1;
      total++; if (bus3.soft_rst !== exp_sr3()) begin bad++; $display("FAIL wdt_soft_rst c=%0d got=%b exp=%b", c, bus3.soft_rst, exp_sr3()); end
      if (bus3.soft_rst[2]) begin n++; if (first < 0) first = c; else if (second < 0) second = c; end
    end
    total++; if (first !== 30 || second !== 60 || n !== 2) begin bad++; $display("FAIL wdt_pulse_times got=%0d,%0d n=%0d exp=30,60 n=2", first, second, n); end
  endtask

  task automatic test_read_suppress();
    int at = -1, n = 0;
    @(negedge clk); bus3.empty = 3'b111; bus3.read_enb = 0;
    @(negedge clk); bus3.empty = 3'b011;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk); #1;
      total++; if (bus3.soft_rst !== exp_sr3()) begin bad++; $display("FAIL rd_soft_rst c=%0d got=%b exp=%b", c, bus3.soft_rst, exp_sr3()); end
      if (bus3.soft_rst[2]) begin n++; at = c; end
      bus3.read_enb = (c == 29) ? 3'b100 : 3'b000;
    end
    total++; if (n !== 1 || at !== 60) begin bad++; $display("FAIL rd_suppress got n=%0d at=%0d exp n=1 at=60", n, at); end
  endtask

  task automatic test_reset_midcount();
    int first = -1;
    @(negedge clk); bus3.empty = 3'b111; bus3.read_enb = 0;
    @(negedge clk); bus3.empty = 3'b000;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk); #1;
      total++; if (bus3.soft_rst !== exp_sr3()) begin bad++; $display("FAIL pre_rst_soft_rst c=%0d got=%b exp=%b", c, bus3.soft_rst, exp_sr3()); end
    end
    rst = 0; #1;
    total++; if (bus3.soft_rst !== 3'b000) begin bad++; $display("FAIL rst_clears_soft_rst got=%b exp=000", bus3.soft_rst); end
    @(negedge clk); rst = 1;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk); #1;
      total++; if (bus3.soft_rst !== exp_sr3()) begin bad++; $display("FAIL post_rst_soft_rst c=%0d got=%b exp=%b", c, bus3.soft_rst, exp_sr3()); end
      if (bus3.soft_rst == 3'b111 && first < 0) first = c;
    end
    total++; if (first !== 30) begin bad++; $display("FAIL post_rst_first_pulse got=%0d exp=30", first); end
    bus3.empty = 3'b111;
  endtask

  task automatic test_param5();
    int n = 0;
    bus5.write_enb_reg = 1;
    for (int d = 0; d < 8; d++) begin
      @(negedge clk); bus5.detect_add = 1; bus5.din = 3'(d);
      @(negedge clk); bus5.detect_add = 0; #1;
      total++; if (bus5.wr_enb !== ((d < 5) ? 5'(1 << d) : 5'b0)) begin bad++; $display("FAIL sweep_wr_enb d=%0d got=%b", d, bus5.wr_enb); end
      total++; if (bus5.addr_err !== (d >= 5)) begin bad++; $display("FAIL sweep_addr_err d=%0d got=%b exp=%b", d, bus5.addr_err, d >= 5); end
    end
    @(negedge clk); bus5.empty = 5'h1f; bus5.read_enb = 0;
    @(negedge clk); bus5.empty = 5'b11110;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk); #1;
      total++; if (bus5.soft_rst !== exp_sr5()) begin bad++; $display("FAIL p5_soft_rst c=%0d got=%b exp=%b", c, bus5.soft_rst, exp_sr5()); end
      if (bus5.soft_rst[0]) n++;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL p5_pulse_count got=%0d exp=4", n); end
  endtask

  task automatic test_random_wdt();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        bus3.empty[i] = $urandom % 32 == 0; bus3.read_enb[i] = $urandom % 64 == 0;
      end
      for (int i = 0; i < 5; i++) begin
        bus5.empty[i] = $urandom % 4 == 0; bus5.read_enb[i] = $urandom % 6 == 0;
      end
      bus3.detect_add = $urandom % 8 == 0; bus3.din = 2'($urandom); bus3.write_enb_reg = 1'($urandom); bus3.full = 3'($urandom);
      bus5.detect_add = $urandom % 8 == 0; bus5.din = 3'($urandom); bus5.write_enb_reg = 1'($urandom); bus5.full = 5'($urandom);
      #1;
      total++; if (bus3.soft_rst !== exp_sr3()) begin bad++; $display("FAIL rw_soft_rst3 c=%0d got=%b exp=%b", c, bus3.soft_rst, exp_sr3()); end
      total++; if (bus5.soft_rst !== exp_sr5()) begin bad++; $display("FAIL rw_soft_rst5 c=%0d got=%b exp=%b", c, bus5.soft_rst, exp_sr5()); end
      total++; if (bus3.vld_out !== ~bus3.empty) begin bad++; $display("FAIL rw_vld_out3 c=%0d got=%b exp=%b", c, bus3.vld_out, ~bus3.empty); end
      total++; if (bus5.vld_out !== ~bus5.empty) begin bad++; $display("FAIL rw_vld_out5 c=%0d got=%b exp=%b", c, bus5.vld_out, ~bus5.empty); end
      total++; if (bus3.wr_enb !== exp_wr3()) begin bad++; $display("FAIL rw_wr_enb3 c=%0d got=%b exp=%b", c, bus3.wr_enb, exp_wr3()); end
      total++; if (bus5.fifo_full !== exp_ff5()) begin bad++; $display("FAIL rw_fifo_full5 c=%0d got=%b exp=%b", c, bus5.fifo_full, exp_ff5()); end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_random_decode();
    test_watchdog();
    test_read_suppress();
    test_reset_midcount();
    test_param5();
    test_random_wdt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
